// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle control FSM for the 32-bit MIPS core: FETCH -> DECODE -> EXEC
// -> (MEM) -> (WB) -> FETCH, with an ILL state for unsupported encodings.
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   opcode, funct         - instruction register fields (stable from DECODE on)
//   zero                  - ALU zero flag, used by beq/bne in EXEC
//   imem_ready            - instruction word valid (only looked at in FETCH)
//   dmem_ready            - data access complete (only looked at in MEM)
//   ir_write, pc_write    - IR / PC load strobes
//   pc_src                - 00 PC+4, 01 branch target, 10 jump target
//   ext_op                - 00 sign-ext, 01 zero-ext, 10 imm<<16
//   alu_src_b, alu_op     - ALU operand B select and operation
//   reg_dst, reg_write    - register-file destination select / write enable
//   mem_to_reg            - write-back data from memory
//   mem_read, mem_write   - data memory requests, held until dmem_ready
//   illegal               - one-cycle pulse in the ILL state
//   state                 - current FSM state (FETCH=0 .. ILL=5)
//   retired               - completed-instruction count, wraps at 2^32
//
// Handshake: a memory request (imem in FETCH, dmem in MEM) is held every
// cycle until the matching ready is seen high; the transfer completes on
// that cycle and the FSM moves on at the following clock edge.
//
// Build option ZERO_EXT_LOGIC_EN: when defined, andi/ori zero-extend their
// immediate (ext_op=01); otherwise they use the sign-extender (ext_op=00).
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  ext_op,
    output logic        alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ILL    = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

`ifdef ZERO_EXT_LOGIC_EN
    localparam logic [1:0] EXT_LOGIC = 2'b01;
`else
    localparam logic [1:0] EXT_LOGIC = 2'b00;
`endif

    state_t cur, nxt;
    logic   retire;
    logic   funct_ok;
    logic   op_ok;
    logic [2:0] r_alu_op;

    // R-type funct decode; funct_ok is the legality check used in DECODE.
    always_comb begin
        funct_ok = 1'b1;
        r_alu_op = ALU_ADD;
        case (funct)
            6'h20:   r_alu_op = ALU_ADD;
            6'h22:   r_alu_op = ALU_SUB;
            6'h24:   r_alu_op = ALU_AND;
            6'h25:   r_alu_op = ALU_OR;
            6'h2A:   r_alu_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_R:                                  op_ok = funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
            OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_J: op_ok = 1'b1;
            default:                               op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_FETCH;
            retired <= 32'd0;
        end else begin
            cur <= nxt;
            if (retire) retired <= retired + 32'd1;
        end
    end

    always_comb begin
        nxt        = cur;
        retire     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ext_op     = 2'b00;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;

        case (cur)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: nxt = op_ok ? S_EXEC : S_ILL;
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op = r_alu_op;
                        nxt    = S_WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op   = ALU_SUB;
                        pc_src   = 2'b01;
                        pc_write = (opcode == OP_BEQ) ? zero : ~zero;
                        retire   = 1'b1;
                        nxt      = S_FETCH;
                    end
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        retire   = 1'b1;
                        nxt      = S_FETCH;
                    end
                    default: begin
                        // I-arith and memory ops: ALU works on the extended
                        // immediate; lui adds imm<<16 to $zero.
                        alu_src_b = 1'b1;
                        case (opcode)
                            OP_SLTI: alu_op = ALU_SLT;
                            OP_ANDI: begin alu_op = ALU_AND; ext_op = EXT_LOGIC; end
                            OP_ORI:  begin alu_op = ALU_OR;  ext_op = EXT_LOGIC; end
                            OP_LUI:  ext_op = 2'b10;
                            default: alu_op = ALU_ADD;
                        endcase
                        nxt = (opcode == OP_LW || opcode == OP_SW) ? S_MEM : S_WB;
                    end
                endcase
            end
            S_MEM: begin
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (dmem_ready) begin
                    if (opcode == OP_LW) begin
                        nxt = S_WB;
                    end else begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_R);
                mem_to_reg = (opcode == OP_LW);
                retire     = 1'b1;
                nxt        = S_FETCH;
            end
            S_ILL: begin
                illegal = 1'b1;
                nxt     = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase

        // Strobes and selects are forced low the same cycle reset is seen.
        if (reset) begin
            retire     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            ext_op     = 2'b00;
            alu_src_b  = 1'b0;
            alu_op     = ALU_ADD;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the 32-bit MIPS core. Sequences fetch, decode, execute, memory and write-back. Drives the extender mode select (sign, zero or LUI) that feeds ALU operand B, along with every register-file, ALU, PC and memory strobe. Sits between the instruction register and the datapath, and handshakes with instruction and data memory.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 6: IR[31:26]; valid from DECODE onward.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag.
- `imem_ready` input 1: instruction word valid this cycle.
- `dmem_ready` input 1: data access complete this cycle.
- `ir_write` output 1: load IR.
- `pc_write` output 1: load PC.
- `pc_src` output 2: 00 PC+4, 01 branch target, 10 jump target.
- `ext_op` output 2: 00 sign-extend, 01 zero-extend, 10 imm<<16.
- `alu_src_b` output 1: 0 register rt, 1 extended immediate.
- `alu_op` output 3: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `reg_dst` output 1: 1 rd, 0 rt.
- `reg_write` output 1: register-file write enable.
- `mem_to_reg` output 1: write-back data from memory.
- `mem_read` output 1: data read request.
- `mem_write` output 1: data write request.
- `illegal` output 1: one-cycle pulse on an unsupported opcode or funct.
- `state` output 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ILL=5.
- `retired` output 32: count of completed instructions.

## Operation
- The state register resets to FETCH and `retired` resets to 0.
- All strobe outputs are 0 while `reset` is high. Selects reset to 0.
- Outputs are decoded combinationally from `state`, `opcode`, `funct` and `zero`. Outputs not listed for a state are 0.
- FETCH:
  - Hold while `imem_ready`=0.
  - When `imem_ready`=1: pulse `ir_write` and `pc_write` with `pc_src`=00, then go to DECODE.
- DECODE:
  - Supported opcodes: 0x00 R, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori, 0x0F lui, 0x02 j.
  - Supported R-type funct values: 0x20, 0x22, 0x24, 0x25, 0x2A.
  - Anything else goes to ILL; otherwise go to EXEC.
- EXEC, R-type: `alu_src_b`=0, `alu_op` taken from funct, then go to WB.
- EXEC, I-arith/lw/sw:
  - `alu_src_b`=1.
  - `ext_op` per instruction: lui=10; andi/ori per Configuration; all others 00.
  - `alu_op`: add for addi/lw/sw/lui (lui adds to $zero), slt for slti, and for andi, or for ori.
  - Next state: MEM for lw/sw, otherwise WB.
- EXEC, beq/bne:
  - `alu_op`=sub, `ext_op`=00, `pc_src`=01.
  - `pc_write` = `zero` for beq, `~zero` for bne.
  - Go to FETCH and increment `retired`.
- EXEC, j: `pc_write`=1, `pc_src`=10, then go to FETCH and increment `retired`.
- MEM:
  - Assert `mem_read` (lw) or `mem_write` (sw) continuously until `dmem_ready`=1.
  - On `dmem_ready`: lw goes to WB; sw goes to FETCH and increments `retired`.
- WB:
  - `reg_write`=1.
  - `reg_dst`=1 only for R-type.
  - `mem_to_reg`=1 only for lw.
  - Go to FETCH and increment `retired`.
- ILL: `illegal`=1 for one cycle, then go to FETCH. `retired` is not incremented.
- `retired` wraps from 0xFFFFFFFF to 0.

## Timing
- R-type and I-arith take 4 cycles. lw takes 5, sw takes 4, beq/bne/j take 3. Memory wait cycles add to each.
- `reset` asserted in any state, including mid-MEM: the next state is FETCH and the in-flight instruction is not retired. Strobes drop in the same cycle `reset` is seen.
- `imem_ready` in states other than FETCH is ignored. `dmem_ready` in states other than MEM is ignored.
- A branch with the condition false still retires. `pc_write` is 0 in that case.

## Configuration
- `ZERO_EXT_LOGIC_EN`:
  - Defined: andi and ori drive `ext_op`=01 (zero-extend).
  - Undefined: they drive `ext_op`=00 (sign-extend, standard extender only), so andi with imm 0x8000 yields 0xFFFF8000.
- lui is unaffected in both cases.

## Test plan
- Reset, then add (op 0x00, funct 0x20) with `imem_ready`=1 every cycle → states 0,1,2,4,0. `reg_write`=1 and `reg_dst`=1 in WB only. `retired`=1.
- lw with `dmem_ready` low for 3 MEM cycles → `mem_read` held for 4 cycles, then WB with `mem_to_reg`=1. Total 8 cycles.
- beq with `zero`=1, then bne with `zero`=1 → EXEC `pc_write` is 1, then 0. `pc_src`=01 both times. `retired` advances by 2.
- andi imm 0x8000 → `ext_op`=01 with `ZERO_EXT_LOGIC_EN`, 00 without. lui → `ext_op`=10.
- Opcode 0x3F → state 5, one `illegal` pulse, return to FETCH. `retired` unchanged.
- `reset` pulsed during a sw MEM wait → `mem_write` drops the same cycle, state=0, `retired`=0.
